// File: rtl/idli_ex_seq_m.sv
// Bit-serial execution sequencer: consumes SLICE_W-bit operand slices LSB-first, producing result
// slices and updating a predicate file and a persistent carry flag at instruction end.
module idli_ex_seq_m #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SLICE_W  = 4,
    parameter int unsigned NUM_PRED = 4,
    localparam int unsigned NSLICE  = DATA_W / SLICE_W,
    localparam int unsigned PIDX_W  = $clog2(NUM_PRED),
    localparam int unsigned CTR_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic                i_ex_gck,
    input  logic                i_ex_rst_n,
    input  logic                i_ex_vld,
    output logic                o_ex_rdy,
    input  logic [1:0]          i_ex_op,
    input  logic                i_ex_inv,
    input  logic                i_ex_cin,
    input  logic                i_ex_cin_sel,
    input  logic                i_ex_wc,
    input  logic [2:0]          i_ex_cmp,
    input  logic [1:0]          i_ex_dst,
    input  logic [PIDX_W-1:0]   i_ex_pidx,
    input  logic                i_ex_cond_en,
    input  logic [PIDX_W-1:0]   i_ex_cond_idx,
    input  logic                i_ex_cond_pol,
    input  logic                i_ex_stall,
    input  logic [SLICE_W-1:0]  i_ex_lhs,
    input  logic [SLICE_W-1:0]  i_ex_rhs,
    output logic [SLICE_W-1:0]  o_ex_out,
    output logic [CTR_W-1:0]    o_ex_slice,
    output logic                o_ex_busy,
    output logic                o_ex_wr_en,
    output logic                o_ex_done,
    output logic [NUM_PRED-1:0] o_ex_pred,
    output logic                o_ex_carry
);

    if (DATA_W % SLICE_W != 0) begin : g_bad_slice
        $error("DATA_W must be a multiple of SLICE_W");
    end
    if (NUM_PRED < 2) begin : g_bad_pred
        $error("NUM_PRED must be at least 2");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic [1:0]          op_q, dst_q;
    logic [2:0]          cmp_q;
    logic                inv_q, cin_q, cin_sel_q, wc_q, run_q;
    logic [PIDX_W-1:0]   pidx_q;
    logic                c_q, c_d, z_q, z_d;
    logic [NUM_PRED-1:0] pred_q, pred_d;
    logic                carry_q, carry_d;

    logic               active, last, accept, run_new;
    logic [SLICE_W-1:0] rhs_x, res;
    logic [SLICE_W:0]   sum;
    logic               cin_s, cout, f_z, f_n, f_v, cmp_res;

    assign active   = (state_q == StRun) & ~i_ex_stall;
    assign last     = (ctr_q == CTR_W'(NSLICE - 1));
    assign o_ex_rdy = (state_q == StIdle) | (active & last);
    assign accept   = i_ex_vld & o_ex_rdy;

    always_comb begin
        rhs_x = inv_q ? ~i_ex_rhs : i_ex_rhs;
        cin_s = (ctr_q == '0) ? (cin_sel_q ? carry_q : cin_q) : c_q;
        sum   = {1'b0, i_ex_lhs} + {1'b0, rhs_x} + {{SLICE_W{1'b0}}, cin_s};
        res   = '0;
        cout  = 1'b0;
        case (op_q)
            2'd0: begin
                res  = sum[SLICE_W-1:0];
                cout = sum[SLICE_W];
            end
            2'd1:    res = i_ex_lhs & rhs_x;
            2'd2:    res = i_ex_lhs | rhs_x;
            default: res = i_ex_lhs ^ rhs_x;
        endcase
    end

    // Flags only matter on the final slice; Z folds in the earlier slices.
    assign f_z = z_q & (res == '0);
    assign f_n = res[SLICE_W-1];
    assign f_v = (op_q == 2'd0) & (i_ex_lhs[SLICE_W-1] == rhs_x[SLICE_W-1])
               & (res[SLICE_W-1] != i_ex_lhs[SLICE_W-1]);

    always_comb begin
        case (cmp_q)
            3'd0:    cmp_res = f_z;
            3'd2:    cmp_res = f_n != f_v;
            3'd3:    cmp_res = ~cout;
            3'd4:    cmp_res = f_n == f_v;
            3'd5:    cmp_res = cout;
            default: cmp_res = ~f_z;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        c_d     = c_q;
        z_d     = z_q;
        pred_d  = pred_q;
        carry_d = carry_q;
        if (active) begin
            if (last) begin
                state_d = StIdle;
                ctr_d   = '0;
                if (run_q && dst_q == 2'd2) pred_d[pidx_q] = cmp_res;
                if (run_q && wc_q) carry_d = cout;
            end else begin
                ctr_d = ctr_q + CTR_W'(1);
                c_d   = cout;
                z_d   = f_z;
            end
        end
        if (accept) begin
            state_d = StRun;
            ctr_d   = '0;
            z_d     = 1'b1;
        end
    end

    // Condition sees the predicate value being written on this same edge.
    assign run_new = ~i_ex_cond_en | (pred_d[i_ex_cond_idx] == i_ex_cond_pol);

    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state_q <= StIdle;
            ctr_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
            pred_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            c_q     <= c_d;
            z_q     <= z_d;
            pred_q  <= pred_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            op_q      <= '0;
            inv_q     <= 1'b0;
            cin_q     <= 1'b0;
            cin_sel_q <= 1'b0;
            wc_q      <= 1'b0;
            cmp_q     <= '0;
            dst_q     <= '0;
            pidx_q    <= '0;
            run_q     <= 1'b0;
        end else if (accept) begin
            op_q      <= i_ex_op;
            inv_q     <= i_ex_inv;
            cin_q     <= i_ex_cin;
            cin_sel_q <= i_ex_cin_sel;
            wc_q      <= i_ex_wc;
            cmp_q     <= i_ex_cmp;
            dst_q     <= i_ex_dst;
            pidx_q    <= i_ex_pidx;
            run_q     <= run_new;
        end
    end

    assign o_ex_out   = (state_q == StRun) ? res : '0;
    assign o_ex_slice = ctr_q;
    assign o_ex_busy  = (state_q == StRun);
    assign o_ex_wr_en = active & run_q & (dst_q == 2'd1);
    assign o_ex_done  = active & last;
    assign o_ex_pred  = pred_q;
    assign o_ex_carry = carry_q;

endmodule

// File: tb/tb_idli_ex_seq_m.sv
// Bench for idli_ex_seq_m: directed and random instructions checked against a whole-word model.
module tb_idli_ex_seq_m;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic vld, rdy, inv, cin, cin_sel, wc, cond_en, cond_pol, stall;
    logic [1:0] op, dst, pidx, cond_idx, slice;
    logic [2:0] cmp;
    logic [3:0] lhs, rhs, out, pred;
    logic busy, wr_en, done, carry;

    always #5 clk = ~clk;

    idli_ex_seq_m dut (
        .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_vld(vld), .o_ex_rdy(rdy),
        .i_ex_op(op), .i_ex_inv(inv), .i_ex_cin(cin), .i_ex_cin_sel(cin_sel), .i_ex_wc(wc),
        .i_ex_cmp(cmp), .i_ex_dst(dst), .i_ex_pidx(pidx), .i_ex_cond_en(cond_en),
        .i_ex_cond_idx(cond_idx), .i_ex_cond_pol(cond_pol), .i_ex_stall(stall),
        .i_ex_lhs(lhs), .i_ex_rhs(rhs), .o_ex_out(out), .o_ex_slice(slice),
        .o_ex_busy(busy), .o_ex_wr_en(wr_en), .o_ex_done(done), .o_ex_pred(pred),
        .o_ex_carry(carry)
    );

    typedef struct {
        logic [1:0]  op, dst, pidx, cond_idx;
        logic        inv, cin, cin_sel, wc, cond_en, cond_pol;
        logic [2:0]  cmp;
        logic [15:0] lhs, rhs;
        int          stall_slice, stall_len;
    } instr_t;

    int n_cmp = 0, n_fail = 0;
    instr_t q[$];
    instr_t cur, t;
    bit m_busy = 0, m_run = 0, m_flag = 0, gaps = 0;
    int m_ctr = 0, stalls_done = 0;
    logic [16:0] m_res = '0;
    logic [3:0] m_pred = '0;
    logic m_carry = 1'b0;

    function automatic instr_t blank();
        instr_t b;
        b.op = 0; b.dst = 0; b.pidx = 0; b.cond_idx = 0; b.inv = 0; b.cin = 0; b.cin_sel = 0;
        b.wc = 0; b.cond_en = 0; b.cond_pol = 0; b.cmp = 0; b.lhs = 0; b.rhs = 0;
        b.stall_slice = 0; b.stall_len = 0;
        return b;
    endfunction

    // Whole-word result: {compare flag, carry, 16-bit result}.
    function automatic logic [17:0] eval(instr_t i, logic cin0);
        logic [15:0] b;
        logic [16:0] r;
        logic z, n, c, v, f;
        b = i.inv ? ~i.rhs : i.rhs;
        case (i.op)
            2'd0:    r = {1'b0, i.lhs} + {1'b0, b} + 17'(cin0);
            2'd1:    r = {1'b0, i.lhs & b};
            2'd2:    r = {1'b0, i.lhs | b};
            default: r = {1'b0, i.lhs ^ b};
        endcase
        z = (r[15:0] == 16'h0);
        n = r[15];
        c = r[16];
        v = (i.op == 2'd0) && (i.lhs[15] == b[15]) && (r[15] != i.lhs[15]);
        case (i.cmp)
            3'd0:    f = z;
            3'd2:    f = (n != v);
            3'd3:    f = !c;
            3'd4:    f = (n == v);
            3'd5:    f = c;
            default: f = !z;
        endcase
        return {f, r};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fields(instr_t i);
        op = i.op; inv = i.inv; cin = i.cin; cin_sel = i.cin_sel; wc = i.wc; cmp = i.cmp;
        dst = i.dst; pidx = i.pidx; cond_en = i.cond_en; cond_idx = i.cond_idx;
        cond_pol = i.cond_pol;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic st, last, exp_rdy, acc;
        st = 1'b0;
        if (m_busy) begin
            st  = (m_ctr == cur.stall_slice) && (stalls_done < cur.stall_len);
            lhs = cur.lhs[m_ctr*4 +: 4];
            rhs = cur.rhs[m_ctr*4 +: 4];
        end else begin
            st  = 1'($urandom_range(0, 1));
            lhs = 4'($urandom);
            rhs = 4'($urandom);
        end
        stall   = st;
        last    = m_busy && (m_ctr == NS - 1);
        exp_rdy = !m_busy || (last && !st);
        vld     = (q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        if (q.size() > 0) drive_fields(q[0]);
        acc = vld && exp_rdy;
        #1;
        check("rdy", 16'(rdy), 16'(exp_rdy));
        check("busy", 16'(busy), 16'(m_busy));
        check("slice", 16'(slice), m_busy ? 16'(m_ctr) : 16'h0);
        check("wr_en", 16'(wr_en), 16'(m_busy && !st && m_run && cur.dst == 2'd1));
        check("done", 16'(done), 16'(last && !st));
        check("out", 16'(out), m_busy ? 16'(m_res[m_ctr*4 +: 4]) : 16'h0);
        check("pred", 16'(pred), 16'(m_pred));
        check("carry", 16'(carry), 16'(m_carry));
        @(posedge clk);
        if (m_busy) begin
            if (st) stalls_done++;
            else if (last) begin
                if (m_run && cur.dst == 2'd2) m_pred[cur.pidx] = m_flag;
                if (m_run && cur.wc) m_carry = m_res[16];
                m_busy = 0;
            end else m_ctr++;
        end
        if (acc) begin
            cur   = q.pop_front();
            m_run = !cur.cond_en || (m_pred[cur.cond_idx] == cur.cond_pol);
            {m_flag, m_res} = eval(cur, cur.cin_sel ? m_carry : cur.cin);
            m_busy = 1; m_ctr = 0; stalls_done = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_busy || q.size() > 0) && k < 2000) begin
            step();
            k++;
        end
        check("drain_timeout", 16'(m_busy || q.size() > 0), 16'h0);
        vld = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; vld = 1'b0; stall = 1'b0; lhs = '0; rhs = '0;
        drive_fields(blank());
        @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 16'(rdy), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_wr_en", 16'(wr_en), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_out", 16'(out), 16'h0);
        check("rst_slice", 16'(slice), 16'h0);
        check("rst_pred", 16'(pred), 16'h0);
        check("rst_carry", 16'(carry), 16'h0);
        rst_n = 1'b1;

        // ADD 0x00FF + 1 to REG
        t = blank(); t.lhs = 16'h00FF; t.rhs = 16'h0001; t.dst = 2'd1; q.push_back(t);
        drain();
        // SUB 5-7, LTU into P2, then GE into P2
        t = blank(); t.lhs = 16'h0005; t.rhs = 16'h0007; t.inv = 1; t.cin = 1;
        t.cmp = 3'd3; t.dst = 2'd2; t.pidx = 2'd2; q.push_back(t);
        drain();
        check("sub_ltu_pred", 16'(pred), 16'h0004);
        t.cmp = 3'd4; q.push_back(t);
        drain();
        check("sub_ge_pred", 16'(pred), 16'h0000);
        // ADD with 2-cycle stall at slice 1
        t = blank(); t.lhs = 16'h00FF; t.rhs = 16'h0001; t.dst = 2'd1;
        t.stall_slice = 1; t.stall_len = 2; q.push_back(t);
        drain();
        // Compare EQ into P1, back-to-back conditional ADDs relying on the bypass
        t = blank(); t.lhs = 16'h1234; t.rhs = 16'h1234; t.inv = 1; t.cin = 1;
        t.cmp = 3'd0; t.dst = 2'd2; t.pidx = 2'd1; q.push_back(t);
        t = blank(); t.lhs = 16'h0011; t.rhs = 16'h0022; t.dst = 2'd1;
        t.cond_en = 1; t.cond_idx = 2'd1; t.cond_pol = 1; q.push_back(t);
        t.cond_pol = 0; q.push_back(t);
        drain();
        check("bypass_pred", 16'(pred), 16'h0002);
        // 32-bit carry chain
        t = blank(); t.lhs = 16'hFFFF; t.rhs = 16'h0001; t.wc = 1; t.dst = 2'd1; q.push_back(t);
        drain();
        check("chain_carry", 16'(carry), 16'h0001);
        t = blank(); t.cin_sel = 1; t.dst = 2'd1; q.push_back(t);
        drain();

        // Random instructions with idle gaps and stalls
        gaps = 1;
        for (int i = 0; i < 250; i++) begin
            t = blank();
            t.op = 2'($urandom); t.inv = 1'($urandom); t.cin = 1'($urandom);
            t.cin_sel = 1'($urandom); t.wc = 1'($urandom); t.cmp = 3'($urandom);
            t.dst = 2'($urandom); t.pidx = 2'($urandom); t.cond_en = 1'($urandom);
            t.cond_idx = 2'($urandom); t.cond_pol = 1'($urandom);
            t.lhs = 16'($urandom); t.rhs = 16'($urandom);
            if ($urandom_range(0, 3) == 0) t.lhs = t.rhs;
            t.stall_slice = $urandom_range(0, 3); t.stall_len = $urandom_range(0, 2);
            q.push_back(t);
        end
        drain();
        gaps = 0;

        // Reset during slice 2 of a PRED-dest compare
        t = blank(); t.lhs = 16'hFFFF; t.rhs = 16'h0001; t.wc = 1; q.push_back(t);
        t = blank(); t.lhs = 16'h0042; t.rhs = 16'h0042; t.inv = 1; t.cin = 1;
        t.dst = 2'd2; t.pidx = 2'd3; q.push_back(t);
        drain();
        check("pre_rst_pred3", 16'(pred[3]), 16'h1);
        t.pidx = 2'd0; q.push_back(t);
        begin
            int k;
            k = 0;
            while (!(m_busy && m_ctr == 2) && k < 20) begin
                step();
                k++;
            end
            check("reach_slice2", 16'(m_busy && m_ctr == 2), 16'h1);
        end
        vld = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_busy = 0; m_pred = '0; m_carry = 1'b0;
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_rdy", 16'(rdy), 16'h1);
        check("abort_pred", 16'(pred), 16'h0);
        check("abort_carry", 16'(carry), 16'h0);
        check("abort_wr_en", 16'(wr_en), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        t = blank(); t.lhs = 16'h0003; t.rhs = 16'h0004; t.dst = 2'd1; q.push_back(t);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/idli_ex_seq_m.md
Name: idli_ex_seq_m

Overview:
- Parametrised bit-serial execution sequencer for the idli core.
- Accepts one pre-decoded instruction per handshake, then consumes operand slices LSB-first over DATA_W/SLICE_W cycles.
- Produces result slices and writes a multi-entry predicate file and a persistent carry flag at instruction end.
- Adds stall, predicated (conditional) execution and multi-word carry chaining on top of the fixed 16-bit/4-bit single-predicate execution stage.

Parameters:
- DATA_W, 16, instruction operand width in bits.
- SLICE_W, 4, bits processed per cycle. DATA_W % SLICE_W must be 0 (elaboration error otherwise).
- NUM_PRED, 4, predicate registers (>=2). PIDX_W = $clog2(NUM_PRED).

Ports:
- i_ex_gck  in  1  clock
- i_ex_rst_n  in  1  reset. Asynchronous, active-low.
- i_ex_vld  in  1  instruction valid
- o_ex_rdy  out  1  ready. Accept = i_ex_vld & o_ex_rdy.
- i_ex_op  in  2  ALU op: 0 ADD, 1 AND, 2 OR, 3 XOR
- i_ex_inv  in  1  invert RHS
- i_ex_cin  in  1  encoded carry-in
- i_ex_cin_sel  in  1  0: use i_ex_cin; 1: use persistent carry flag
- i_ex_wc  in  1  write persistent carry flag at end
- i_ex_cmp  in  3  0 EQ, 1 NE, 2 LT, 3 LTU, 4 GE, 5 GEU, others NE
- i_ex_dst  in  2  0 NONE, 1 REG, 2 PRED
- i_ex_pidx  in  PIDX_W  destination predicate index
- i_ex_cond_en  in  1  conditional execution enable
- i_ex_cond_idx  in  PIDX_W  condition predicate index
- i_ex_cond_pol  in  1  execute when pred[cond_idx] == pol
- i_ex_stall  in  1  freeze current slice
- i_ex_lhs  in  SLICE_W  LHS operand slice
- i_ex_rhs  in  SLICE_W  RHS operand slice
- o_ex_out  out  SLICE_W  result slice (combinational)
- o_ex_slice  out  $clog2(DATA_W/SLICE_W)  current slice index
- o_ex_busy  out  1  in RUN state
- o_ex_wr_en  out  1  register write enable for this slice
- o_ex_done  out  1  final slice completing this cycle
- o_ex_pred  out  NUM_PRED  predicate file
- o_ex_carry  out  1  persistent carry flag

Behaviour:
- N = DATA_W/SLICE_W. States: IDLE, RUN.
- Reset values: IDLE, slice ctr 0, all preds 0, carry 0, o_ex_rdy 1, o_ex_busy/o_ex_wr_en/o_ex_done 0, o_ex_out 0.
- Accept at edge T:
  - Capture all control fields and the run bit: run = !cond_en | (pred_eff[cond_idx] == cond_pol).
  - Go to RUN with ctr 0.
  - Slice k is processed in the cycle where ctr == k; the first slice is at T+1.
- RUN cycle, !stall:
  - ALU computes on i_ex_lhs with rhs' = inv ? ~i_ex_rhs : i_ex_rhs.
  - Carry-in: slice 0 uses (cin_sel ? carry flag : cin); later slices use the saved slice carry-out.
  - ctr advances. Logical ops produce carry-out 0.
- Stall: ctr, saved carry and Z accumulator hold. o_ex_wr_en=0 and o_ex_done=0. o_ex_out still reflects inputs.
- o_ex_wr_en = RUN & !stall & run & dst==REG.
- Flags are evaluated on the last slice:
  - Z = all slices zero (accumulated).
  - N = MSB of result.
  - C = carry-out of MSB.
  - V = signed overflow of the MSB slice.
- Compare mapping:
  - EQ: Z
  - NE: !Z
  - LT: N!=V
  - LTU: !C
  - GE: N==V
  - GEU: C
- Last slice (ctr==N-1, !stall):
  - o_ex_done=1.
  - If run & dst==PRED, pred[pidx] is updated at the edge.
  - If run & wc, carry flag <= C.
  - Next state: IDLE, or RUN with ctr 0 if a new accept occurs that cycle.
- o_ex_rdy = IDLE | (RUN & ctr==N-1 & !stall). This gives back-to-back throughput of one instruction per N cycles.
- Squashed instruction (run=0): still consumes N slice cycles. No REG, PRED or carry write.
- Predicate bypass: pred_eff is the value after the same-edge final-slice write.
  - If accept coincides with the previous instruction's final slice writing pred[pidx] == cond_idx, the condition uses the new value.
  - Carry-flag reads for cin_sel are bypassed the same way.
- Invalid dst encoding 3 is treated as NONE.
- Reset mid-operation aborts the instruction. No partial pred or carry update survives.

Test Plan:
- ADD 0x00FF+0x0001, dst REG (16/4) -> o_ex_out slices 0x0,0x0,0x1,0x0; wr_en high 4 cycles; done on 4th.
- SUB (inv=1, cin=1) 0x0005-0x0007, cmp LTU, dst PRED pidx 2 -> pred = 4'b0100. Repeat with GE -> pred[2]=0.
- Same ADD with stall held 2 cycles at slice 1 -> ctr holds at 1; result unchanged; done 2 cycles later (cycle 6); rdy low until then.
- CMP EQ 0x1234,0x1234 -> P1=1, immediately followed by ADD cond_en idx1 pol1 -> executes (bypass), wr_en asserted. Repeat with pol0 -> squashed, wr_en never high, 4 cycles consumed.
- 32-bit chain: ADD 0xFFFF+0x0001 wc=1 -> out 0x0000, carry=1; then ADD 0x0000+0x0000 cin_sel=1 -> out 0x0001.
- Reset asserted at slice 2 of a PRED-dest compare -> IDLE, preds 0, rdy 1 on next cycle.
